// File: rtl/imm_pkg.sv
// Shared types for the immediate-generation stage: format codes, opcodes and the
// buffered entry layout.
package imm_pkg;

    // Entries are sized for the widest datapath; narrower builds use the low bits.
    localparam int unsigned XLEN_MAX = 64;

    typedef enum logic [2:0] {
        FmtR     = 3'd0,
        FmtI     = 3'd1,
        FmtS     = 3'd2,
        FmtB     = 3'd3,
        FmtU     = 3'd4,
        FmtJ     = 3'd5,
        FmtShamt = 3'd6,
        FmtCsr   = 3'd7
    } imm_fmt_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        imm_fmt_t            fmt;
        logic [XLEN_MAX-1:0] target;
        logic                illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder; also forms pc+imm for branch, jump
// and AUIPC targets.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          SUPPORT_U = 1'b1
) (
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output imm_entry_t      entry
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    imm_fmt_t        fmt;
    logic            illegal;
    logic            use_target;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    always_comb begin
        imm        = '0;
        fmt        = FmtR;
        illegal    = 1'b0;
        use_target = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            unique case (opcode)
                OPC_LOAD, OPC_JALR: begin
                    imm = XLEN'($signed(in_instr[31:20]));
                    fmt = FmtI;
                end
                OPC_OPIMM: begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        fmt = FmtShamt;
                        imm = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
                    end else begin
                        fmt = FmtI;
                        imm = XLEN'($signed(in_instr[31:20]));
                    end
                end
                OPC_STORE: begin
                    imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                    fmt = FmtS;
                end
                OPC_BRANCH: begin
                    imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                         in_instr[11:8], 1'b0}));
                    fmt        = FmtB;
                    use_target = 1'b1;
                end
                OPC_LUI, OPC_AUIPC: begin
                    if (SUPPORT_U) begin
                        imm        = XLEN'($signed({in_instr[31:12], 12'b0}));
                        fmt        = FmtU;
                        use_target = (opcode == OPC_AUIPC);
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OPC_JAL: begin
                    imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                         in_instr[30:21], 1'b0}));
                    fmt        = FmtJ;
                    use_target = 1'b1;
                end
                OPC_SYSTEM: begin
                    imm = XLEN'(in_instr[31:20]);
                    fmt = FmtCsr;
                end
                OPC_OP: begin
                    fmt = FmtR;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

    // Modular add: wrap-around is intentional.
    assign target = use_target ? (in_pc + imm) : in_pc;

    always_comb begin
        entry         = '0;
        entry.imm     = XLEN_MAX'(imm);
        entry.fmt     = fmt;
        entry.target  = XLEN_MAX'(target);
        entry.illegal = illegal;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: decoder in front of a MAIN/SKID two-entry
// buffer giving full throughput with a registered in_ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          SUPPORT_U = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_fmt_t        out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_t;

    state_t     state_q;
    imm_entry_t main_q;
    imm_entry_t skid_q;
    imm_entry_t dec_entry;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       push;
    logic       pop;

    imm_decode #(
        .XLEN      (XLEN),
        .SUPPORT_U (SUPPORT_U)
    ) u_decode (
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .entry    (dec_entry)
    );

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        main_q      <= dec_entry;
                        state_q     <= StOne;
                        out_valid_q <= 1'b1;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_q <= dec_entry;
                    end else if (pop) begin
                        state_q     <= StEmpty;
                        out_valid_q <= 1'b0;
                    end else if (push) begin
                        skid_q     <= dec_entry;
                        state_q    <= StTwo;
                        in_ready_q <= 1'b0;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a pop can move us.
                    if (pop) begin
                        main_q     <= skid_q;
                        state_q    <= StOne;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = main_q.imm[XLEN-1:0];
    assign out_fmt     = main_q.fmt;
    assign out_target  = main_q.target[XLEN-1:0];
    assign out_illegal = main_q.illegal;

    if (XLEN < XLEN_MAX) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{main_q.imm[XLEN_MAX-1:XLEN], main_q.target[XLEN_MAX-1:XLEN]};
    end

endmodule
